dmem_port_arbiter: RTL and testbench

//  Shares the single 32-bit data-memory port between the pipeline MEM stage (CPU) and a

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arb_wait_ctr.sv | 37 +++
 rtl/dmem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W   = 7;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_MAX_WAIT = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DBG
  } owner_e;

  typedef enum logic {
    ARB,
    DBG_LOCK
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating count of consecutive cycles the debug port asked and lost;
// limit_o tells the arbiter the debug port must win the next conflict.
module dmem_arb_wait_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic limit_o
);

  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the CPU MEM stage and a debug/loader port.
// Optional conflict counter output enabled by defining DMEM_ARB_STATS_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  arb_state_e        state_q, state_d;
  owner_e            resp_owner_q, resp_owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              wait_limit;

  dmem_arb_wait_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_ctr (
    .clk_i   (clk),
    .rst_ni  (reset),
    .inc_i   (dbg_req & ~dbg_gnt),
    .clr_i   (~dbg_req | dbg_gnt),
    .limit_o (wait_limit)
  );

  // Grants are forced low while reset is asserted so no strobe escapes.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset) begin
      if (state_q == DBG_LOCK) begin
        dbg_gnt = dbg_req;
      end else if (cpu_req && dbg_req) begin
        cpu_gnt = ~wait_limit;
        dbg_gnt = wait_limit;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end
  end

  assign cpu_stall = reset & cpu_req & ~cpu_gnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:      if (dbg_gnt && dbg_lock) state_d = DBG_LOCK;
      DBG_LOCK: if (!dbg_lock)           state_d = ARB;
      default:                           state_d = ARB;
    endcase
  end

  assign mem_en    = cpu_gnt | dbg_gnt;
  assign mem_we    = dbg_gnt ? dbg_we    : (cpu_gnt & cpu_we);
  assign mem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
  assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;

  always_comb begin
    resp_owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) begin
      resp_owner_d = OWN_CPU;
    end else if (dbg_gnt && !dbg_we) begin
      resp_owner_d = OWN_DBG;
    end
  end

  // Read data is forwarded straight from memory in the response cycle and held afterwards.
  assign cpu_rvalid = (resp_owner_q == OWN_CPU);
  assign dbg_rvalid = (resp_owner_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB;
      resp_owner_q <= OWN_NONE;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      resp_owner_q <= resp_owner_d;
      cpu_rdata_q  <= cpu_rdata;
      dbg_rdata_q  <= dbg_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_q <= '0;
    end else if (cpu_req && dbg_req && (conflict_q != '1)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and random checks of dmem_port_arbiter against a cycle-level reference model.
module tb_dmem_port_arbiter;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata, cpu_rdata, dbg_rdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   conflict_cnt;
`endif

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural data memory: word-addressed, one-cycle read latency.
  logic [DW-1:0] ram [32];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[6:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[6:2]];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit            m_lock;
  int            m_starve;
  int            m_pend;        // 0 none, 1 cpu, 2 dbg
  logic [DW-1:0] m_pend_data, m_cpu_last, m_dbg_last;
  logic [DW-1:0] m_mem [32];
  int            m_conf;
  bit            g_cpu, g_dbg;
  logic          o_cpu_gnt, o_dbg_gnt, o_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_now();
    bit ec, ed;
    ec = 1'b0;
    ed = 1'b0;
    if (reset) begin
      if (m_lock) ed = dbg_req;
      else if (cpu_req && dbg_req) begin
        ed = (m_starve >= MW);
        ec = !ed;
      end else begin
        ec = cpu_req;
        ed = dbg_req;
      end
    end
    g_cpu = ec;
    g_dbg = ed;
    o_cpu_gnt = cpu_gnt;
    o_dbg_gnt = dbg_gnt;
    o_stall   = cpu_stall;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(ec));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(ed));
    chk("cpu_stall", 32'(cpu_stall), 32'(reset && cpu_req && !ec));
    chk("mem_en", 32'(mem_en), 32'(ec || ed));
    chk("mem_we", 32'(mem_we), 32'((ec && cpu_we) || (ed && dbg_we)));
    if (ec || ed) begin
      chk("mem_addr", 32'(mem_addr), 32'(ed ? dbg_addr : cpu_addr));
      chk("mem_wdata", mem_wdata, ed ? dbg_wdata : cpu_wdata);
    end
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend == 1));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_pend == 2));
    chk("cpu_rdata", cpu_rdata, (m_pend == 1) ? m_pend_data : m_cpu_last);
    chk("dbg_rdata", dbg_rdata, (m_pend == 2) ? m_pend_data : m_dbg_last);
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      if (m_pend == 1) m_cpu_last = m_pend_data;
      if (m_pend == 2) m_dbg_last = m_pend_data;
      m_pend = 0;
      if (g_cpu) begin
        if (cpu_we) m_mem[cpu_addr[6:2]] = cpu_wdata;
        else begin m_pend = 1; m_pend_data = m_mem[cpu_addr[6:2]]; end
      end
      if (g_dbg) begin
        if (dbg_we) m_mem[dbg_addr[6:2]] = dbg_wdata;
        else begin m_pend = 2; m_pend_data = m_mem[dbg_addr[6:2]]; end
      end
      if (g_dbg || !dbg_req) m_starve = 0;
      else if (m_starve < MW) m_starve++;
      m_lock = m_lock ? dbg_lock : (g_dbg && dbg_lock);
      if (cpu_req && dbg_req && m_conf < 65535) m_conf++;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    #1 check_now();
    advance();
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic lk, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    dbg_req = req; dbg_we = we; dbg_lock = lk; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic do_reset();
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, 0, '0, '0);
    reset = 1'b0;
    m_lock = 0; m_starve = 0; m_pend = 0; m_cpu_last = '0; m_dbg_last = '0; m_conf = 0;
    #1 check_now();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // Load every memory word through the debug port
    for (int i = 0; i < 32; i++) begin
      set_dbg(1, 1, 0, AW'(i * 4), (i == 4) ? 32'hDEADBEEF : $urandom);
      cycle();
    end
    set_dbg(0, 0, 0, '0, '0);

    // CPU read alone
    set_cpu(1, 0, 7'h10, '0);
    cycle();
    chk("t1_gnt", 32'(o_cpu_gnt), 32'd1);
    set_cpu(0, 0, '0, '0);
    #1;
    chk("t1_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    cycle();

    // Sustained conflict: debug port forced through after MAX_WAIT losses
    set_cpu(1, 1, 7'h40, 32'hA5A5_0001);
    set_dbg(1, 1, 0, 7'h44, 32'h5A5A_0002);
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("t2_cpu_gnt", 32'(o_cpu_gnt), 32'(k != 4));
      chk("t2_stall", 32'(o_stall), 32'(k == 4));
    end
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, 0, '0, '0);
    cycle();

    // Locked debug burst blocks the CPU for its whole length
    set_cpu(1, 1, 7'h48, 32'hC0DE_0048);
    set_dbg(1, 1, 1, 7'h00, 32'hB000_0000);
    repeat (4) cycle();
    cycle();
    chk("t3_stall0", 32'(o_stall), 32'd1);
    set_dbg(1, 1, 1, 7'h04, 32'hB000_0004);
    cycle();
    chk("t3_stall1", 32'(o_stall), 32'd1);
    set_dbg(1, 1, 0, 7'h08, 32'hB000_0008);
    cycle();
    chk("t3_stall2", 32'(o_stall), 32'd1);
    chk("t3_dbg_gnt2", 32'(o_dbg_gnt), 32'd1);
    set_dbg(0, 0, 0, '0, '0);
    cycle();
    chk("t3_cpu_gnt", 32'(o_cpu_gnt), 32'd1);
    set_cpu(0, 0, '0, '0);

    // Write by debug then immediate CPU read of the same word
    set_dbg(1, 1, 0, 7'h20, 32'h12345678);
    cycle();
    set_dbg(0, 0, 0, '0, '0);
    set_cpu(1, 0, 7'h20, '0);
    cycle();
    set_cpu(0, 0, '0, '0);
    #1 chk("t4_rdata", cpu_rdata, 32'h12345678);
    cycle();

    // Reset inside a locked burst with a read outstanding
    set_dbg(1, 0, 1, 7'h30, '0);
    cycle();
    do_reset();
    #1 chk("t5_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("t5_dbg_rdata", dbg_rdata, 32'd0);
    cycle();

    // Ten conflict cycles after reset; first one proves the arbiter left DBG_LOCK
    set_cpu(1, 1, 7'h50, 32'h0000_0050);
    set_dbg(1, 1, 0, 7'h54, 32'h0000_0054);
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (k == 0) chk("t5_cpu_wins", 32'(o_cpu_gnt), 32'd1);
    end
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, 0, '0, '0);
`ifdef DMEM_ARB_STATS_EN
    #1 chk("t6_conflicts", 32'(conflict_cnt), 32'd10);
`endif
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 127)), $urandom);
      set_dbg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              AW'($urandom_range(0, 127)), $urandom);
      cycle();
    end
    set_cpu(0, 0, '0, '0);
    set_dbg(0, 0, 0, '0, '0);
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
